// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit shared types: datapath width, lane width, FSM states.
// Ports: none (package).
package mem_access_unit_pkg;

  localparam int FULLW  = 32;
  localparam int LANE_W = 2;

  typedef enum logic [1:0] {
    MAU_IDLE    = 2'd0,
    MAU_LD_WAIT = 2'd1,
    MAU_RMW     = 2'd2
  } mau_state_e;

  function automatic logic [FULLW-1:0] word_align(
    input logic [FULLW-1:0] a
  );
    return {a[FULLW-1:LANE_W], {LANE_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// MEM-stage request/response bundle for mem_access_unit.
// Ports: req_valid/ready/store/byte/addr/wdata, rsp_valid/data/err.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_store;
  logic             req_byte;
  logic [FULLW-1:0] req_addr;
  logic [FULLW-1:0] req_wdata;
  logic             rsp_valid;
  logic [FULLW-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req_valid, req_store, req_byte,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_store, req_byte,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Big-endian byte lane extract/merge (lane 0 = [31:24]).
// Ports: word_i, lane_i, byte_i in; byte_o (zero-ext), merged_o out.
module mem_access_unit_byte_lane
  import mem_access_unit_pkg::*;
(
  input  logic [FULLW-1:0]  word_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [7:0]        byte_i,
  output logic [FULLW-1:0]  byte_o,
  output logic [FULLW-1:0]  merged_o
);

  logic [4:0]       sh;
  logic [FULLW-1:0] mask;
  logic [FULLW-1:0] shifted;

  // lane 0 sits in the top byte, so shift = (3 - lane) * 8
  assign sh       = {~lane_i, 3'b000};
  assign shifted  = word_i >> sh;
  assign mask     = {{(FULLW-8){1'b0}}, 8'hFF} << sh;
  assign byte_o   = {{(FULLW-8){1'b0}}, shifted[7:0]};
  assign merged_o = (word_i & ~mask)
                  | ({{(FULLW-8){1'b0}}, byte_i} << sh);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for the data ram: checks, byte RMW, response.
// Ports: clk, rst_n, bus (slave), ram_wd/wa/we/ra out, ram_out in.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus,
  output logic [FULLW-1:0] ram_wd_o,
  output logic [FULLW-1:0] ram_wa_o,
  output logic             ram_we_o,
  output logic [FULLW-1:0] ram_ra_o,
  input  logic [FULLW-1:0] ram_out_i
);

  mau_state_e        state_q;
  logic [FULLW-1:0]  addr_q;
  logic [LANE_W-1:0] lane_q;
  logic              byte_q;
  logic [7:0]        wbyte_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [FULLW-1:0]  rsp_data_q;

  logic             idle;
  logic             rmw;
  logic             accept;
  logic             err;
  logic             wr_now;
  logic [FULLW-1:0] req_al;
  logic [FULLW-1:0] lane_byte;
  logic [FULLW-1:0] merged;

  assign idle   = (state_q == MAU_IDLE);
  assign rmw    = (state_q == MAU_RMW);
  assign accept = bus.req_valid & idle;
  assign req_al = word_align(bus.req_addr);
  assign err    = (!bus.req_byte && bus.req_addr[1:0] != 2'b00)
               || ((bus.req_addr >> ADDR_WIDTH) != '0);
  assign wr_now = accept & ~err & bus.req_store & ~bus.req_byte;

  mem_access_unit_byte_lane u_lane (
    .word_i   (ram_out_i),
    .lane_i   (lane_q),
    .byte_i   (wbyte_q),
    .byte_o   (lane_byte),
    .merged_o (merged)
  );

  assign bus.req_ready = idle;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;

  // gated by rst_n so a reset landing mid-RMW cannot write
  assign ram_we_o = rst_n & (wr_now | rmw);
  assign ram_wa_o = rmw ? addr_q : req_al;
  assign ram_wd_o = rmw ? merged : bus.req_wdata;
  assign ram_ra_o = idle ? req_al : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MAU_IDLE;
      addr_q      <= '0;
      lane_q      <= '0;
      byte_q      <= 1'b0;
      wbyte_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      case (state_q)
        MAU_IDLE: begin
          if (accept) begin
            if (err) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (bus.req_store && !bus.req_byte) begin
              rsp_valid_q <= 1'b1;
            end else begin
              addr_q  <= req_al;
              lane_q  <= bus.req_addr[1:0];
              byte_q  <= bus.req_byte;
              wbyte_q <= bus.req_wdata[7:0];
              state_q <= bus.req_store ? MAU_RMW
                                       : MAU_LD_WAIT;
            end
          end
        end
        MAU_LD_WAIT: begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= byte_q ? lane_byte : ram_out_i;
          state_q     <= MAU_IDLE;
        end
        MAU_RMW: begin
          rsp_valid_q <= 1'b1;
          state_q     <= MAU_IDLE;
        end
        default: state_q <= MAU_IDLE;
      endcase
    end
  end

endmodule
